// File: rtl/sdft_sample_feeder.sv
`default_nettype none
// ============================================================================
// Module      : sdft_sample_feeder
// Description : Input feeder for a sliding-DFT bin-update engine. Buffers
//               incoming samples in a small FIFO and keeps an FFT_SIZE-deep
//               ring of the analysis window. When the SDFT is idle it pops one
//               sample, presents it as SAMPLE together with the sample it
//               evicts from the window (OLDEST_SAMPLE), and pulses
//               start_compute for one cycle.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               in_valid/in_sample  - input sample stream
//               in_ready            - FIFO not full
//               sdft_busy           - downstream engine busy
//               start_compute       - one-cycle issue pulse
//               SAMPLE              - newest sample (held until next issue)
//               OLDEST_SAMPLE       - evicted sample, 0 until window full
//               window_full         - FFT_SIZE samples written since reset
//               overflow_count      - saturating count of dropped samples
// Revision    : 1.0 - initial release
// ============================================================================
module sdft_sample_feeder #(
    parameter int WORD_WIDTH = 16,
    parameter int FFT_SIZE   = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [WORD_WIDTH-1:0] in_sample,
    output logic                  in_ready,
    input  logic                  sdft_busy,
    output logic                  start_compute,
    output logic [WORD_WIDTH-1:0] SAMPLE,
    output logic [WORD_WIDTH-1:0] OLDEST_SAMPLE,
    output logic                  window_full,
    output logic [15:0]           overflow_count
);

    localparam int c_PTR_W  = $clog2(FFT_SIZE);
    localparam int c_FILL_W = $clog2(FFT_SIZE + 1);
    localparam int c_FPTR_W = $clog2(FIFO_DEPTH);
    localparam int c_FCNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [c_FILL_W-1:0] c_FILL_MAX = c_FILL_W'(FFT_SIZE);
    localparam logic [c_FCNT_W-1:0] c_FIFO_MAX = c_FCNT_W'(FIFO_DEPTH);

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_READ  = 3'd1;
    localparam logic [2:0] c_S_LATCH = 3'd2;
    localparam logic [2:0] c_S_ISSUE = 3'd3;
    localparam logic [2:0] c_S_HOLD  = 3'd4;
    localparam logic [2:0] c_S_WAIT  = 3'd5;

    // ------------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------------
    logic [WORD_WIDTH-1:0] r_fifo_mem [FIFO_DEPTH];
    logic [c_FPTR_W-1:0]   r_fifo_wr;
    logic [c_FPTR_W-1:0]   r_fifo_rd;
    logic [c_FCNT_W-1:0]   r_fifo_cnt;
    logic [15:0]           r_overflow;

    logic [2:0] r_state;
    logic [2:0] w_next_state;

    logic w_fifo_full;
    logic w_fifo_empty;
    logic w_push;
    logic w_pop;

    // Full/empty come only from registered count so in_ready never depends
    // on a same-cycle pop.
    assign w_fifo_full  = (r_fifo_cnt == c_FIFO_MAX);
    assign w_fifo_empty = (r_fifo_cnt == '0);
    assign w_push       = in_valid && !w_fifo_full;
    assign w_pop        = (r_state == c_S_IDLE) && !w_fifo_empty && !sdft_busy;

    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_fifo_mem[r_fifo_wr] <= in_sample;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fifo_wr  <= '0;
            r_fifo_rd  <= '0;
            r_fifo_cnt <= '0;
            r_overflow <= '0;
        end else begin
            if (w_push) begin
                r_fifo_wr <= r_fifo_wr + c_FPTR_W'(1);
            end
            if (w_pop) begin
                r_fifo_rd <= r_fifo_rd + c_FPTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + c_FCNT_W'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - c_FCNT_W'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
            if (in_valid && w_fifo_full && (r_overflow != 16'hFFFF)) begin
                r_overflow <= r_overflow + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Window ring RAM: single port, address is always the write pointer.
    // The read is read-first, so the evicted word is captured in IDLE/READ
    // before LATCH overwrites the same location.
    // ------------------------------------------------------------------------
    logic [WORD_WIDTH-1:0] r_ram [FFT_SIZE];
    logic [WORD_WIDTH-1:0] r_ram_q;
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [WORD_WIDTH-1:0] r_sample_reg;
    logic                  w_ram_we;

    assign w_ram_we = (r_state == c_S_LATCH) && !reset;

    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_ram[r_wr_ptr] <= r_sample_reg;
        end
        r_ram_q <= r_ram[r_wr_ptr];
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    logic [c_FILL_W-1:0]   r_fill;
    logic [WORD_WIDTH-1:0] r_sample;
    logic [WORD_WIDTH-1:0] r_oldest;
    logic                  r_window_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_fill        <= '0;
            r_sample      <= '0;
            r_oldest      <= '0;
            r_sample_reg  <= '0;
            r_window_full <= 1'b0;
        end else begin
            r_window_full <= (r_fill == c_FILL_MAX);
            if (w_pop) begin
                r_sample_reg <= r_fifo_mem[r_fifo_rd];
            end
            if (r_state == c_S_LATCH) begin
                // Until the window has been filled once, the RAM word is
                // stale and the evicted value is defined as zero.
                r_oldest <= (r_fill == c_FILL_MAX) ? r_ram_q : '0;
                r_sample <= r_sample_reg;
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                if (r_fill != c_FILL_MAX) begin
                    r_fill <= r_fill + c_FILL_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE:  if (!w_fifo_empty && !sdft_busy) w_next_state = c_S_READ;
            c_S_READ:  w_next_state = c_S_LATCH;
            c_S_LATCH: w_next_state = c_S_ISSUE;
            c_S_ISSUE: w_next_state = c_S_HOLD;
            // HOLD covers the cycle before the engine raises sdft_busy.
            c_S_HOLD:  w_next_state = c_S_WAIT;
            c_S_WAIT:  if (!sdft_busy) w_next_state = c_S_IDLE;
            default:   w_next_state = c_S_IDLE;
        endcase
    end

    assign in_ready       = !w_fifo_full;
    assign start_compute  = (r_state == c_S_ISSUE);
    assign SAMPLE         = r_sample;
    assign OLDEST_SAMPLE  = r_oldest;
    assign window_full    = r_window_full;
    assign overflow_count = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_sdft_sample_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdft_sample_feeder
// Description : Self-checking bench for sdft_sample_feeder. A queue-based
//               reference model predicts in_ready, start_compute, SAMPLE,
//               OLDEST_SAMPLE, window_full and overflow_count every cycle;
//               literal expectations pin key boundary points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdft_sample_feeder;

    localparam int WW = 16;
    localparam int N  = 256;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [WW-1:0] in_sample = '0;
    logic          in_ready;
    logic          sdft_busy;
    logic          start_compute;
    logic [WW-1:0] SAMPLE;
    logic [WW-1:0] OLDEST_SAMPLE;
    logic          window_full;
    logic [15:0]   overflow_count;

    always #5 clk = ~clk;

    sdft_sample_feeder #(
        .WORD_WIDTH (WW),
        .FFT_SIZE   (N),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_sample      (in_sample),
        .in_ready       (in_ready),
        .sdft_busy      (sdft_busy),
        .start_compute  (start_compute),
        .SAMPLE         (SAMPLE),
        .OLDEST_SAMPLE  (OLDEST_SAMPLE),
        .window_full    (window_full),
        .overflow_count (overflow_count)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fails++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // ------------------------------------------------------------------------
    // Downstream SDFT model: busy starts the cycle after start_compute.
    // ------------------------------------------------------------------------
    int busy_len     = 256;
    bit rand_busy    = 1'b0;
    bit force_busy   = 1'b0;
    bit busy_pending = 1'b0;
    int busy_cnt     = 0;

    assign sdft_busy = force_busy || (busy_cnt > 0);

    always @(posedge clk) begin
        #2;
        if (reset) begin
            busy_cnt     = 0;
            busy_pending = 1'b0;
        end else if (busy_pending) begin
            busy_pending = 1'b0;
            busy_cnt     = rand_busy ? int'($urandom_range(0, 4)) : busy_len;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
    end

    // ------------------------------------------------------------------------
    // Reference model and per-cycle compare (sampled on the falling edge)
    // ------------------------------------------------------------------------
    int cyc       = 0;
    bit eng_idle  = 1'b1;
    int issue_at  = -10;
    int cur       = 0;
    int fq[$];
    int hist[$];
    int exp_sample = 0;
    int exp_oldest = 0;
    int exp_ovf    = 0;
    int wf_at      = -1;
    int rec_s[$];
    int rec_o[$];
    int rec_w[$];

    always @(negedge clk) begin : monitor
        int n;
        bit exp_ready;
        bit exp_start;
        if (reset) begin
            fq.delete();
            hist.delete();
            rec_s.delete();
            rec_o.delete();
            rec_w.delete();
            eng_idle   = 1'b1;
            issue_at   = -10;
            exp_sample = 0;
            exp_oldest = 0;
            exp_ovf    = 0;
            wf_at      = -1;
        end else begin
            exp_ready = (fq.size() < FD);
            exp_start = !eng_idle && (cyc == issue_at);
            if (exp_start) begin
                n          = hist.size() + 1;
                exp_sample = cur;
                exp_oldest = (n > N) ? hist[n - 1 - N] : 0;
                hist.push_back(cur);
                if (n == N) wf_at = cyc + 1;
            end
            check("in_ready", int'(in_ready), int'(exp_ready));
            check("start_compute", int'(start_compute), int'(exp_start));
            check("SAMPLE", int'($signed(SAMPLE)), exp_sample);
            check("OLDEST_SAMPLE", int'($signed(OLDEST_SAMPLE)), exp_oldest);
            check("overflow_count", int'(overflow_count), exp_ovf);
            check("window_full", int'(window_full), int'(wf_at >= 0 && cyc >= wf_at));
            if (start_compute) begin
                rec_s.push_back(int'($signed(SAMPLE)));
                rec_o.push_back(int'($signed(OLDEST_SAMPLE)));
                rec_w.push_back(int'(window_full));
                busy_pending = 1'b1;
            end
            // Issue engine: pops only from samples already in the FIFO.
            if (eng_idle) begin
                if (fq.size() > 0 && !sdft_busy) begin
                    cur      = fq.pop_front();
                    issue_at = cyc + 3;
                    eng_idle = 1'b0;
                end
            end else if (cyc >= issue_at + 2 && !sdft_busy) begin
                eng_idle = 1'b1;
            end
            if (in_valid) begin
                if (exp_ready) fq.push_back(int'($signed(in_sample)));
                else if (exp_ovf < 16'hFFFF) exp_ovf++;
            end
        end
        cyc++;
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (inputs change 2 time units after the rising edge)
    // ------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        in_valid   = 1'b0;
        force_busy = 1'b0;
        step();
        step();
        reset = 1'b0;
        check("rst_start_compute", int'(start_compute), 0);
        check("rst_SAMPLE", int'(SAMPLE), 0);
        check("rst_OLDEST", int'(OLDEST_SAMPLE), 0);
        check("rst_window_full", int'(window_full), 0);
        check("rst_overflow", int'(overflow_count), 0);
        check("rst_in_ready", int'(in_ready), 1);
    endtask

    task automatic push_val(input int v);
        int g = 0;
        in_valid = 1'b0;
        while (!in_ready && g < 5000) begin
            step();
            g++;
        end
        if (g >= 5000) timeout_fail("push_wait");
        in_valid  = 1'b1;
        in_sample = 16'(v);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_issues(input int k, input int budget);
        int g = 0;
        while (rec_s.size() < k && g < budget) begin
            step();
            g++;
        end
        if (rec_s.size() < k) timeout_fail("wait_issues");
    endtask

    int vals[701];

    initial begin : stim
        int r;
        for (int n = 1; n <= 700; n++) begin
            if (n <= 300)      vals[n] = n;
            else if (n == 400) vals[n] = -32768;
            else if (n == 401) vals[n] = 32767;
            else begin
                r = int'($urandom_range(0, 65535));
                vals[n] = (r > 32767) ? r - 65536 : r;
            end
        end

        do_reset();

        // Three samples with a long downstream busy period.
        rand_busy = 1'b0;
        busy_len  = 256;
        push_val(1);
        push_val(2);
        push_val(3);
        wait_issues(3, 3000);
        if (rec_s.size() >= 3) begin
            for (int k = 0; k < 3; k++) begin
                check("t1_sample", rec_s[k], k + 1);
                check("t1_oldest", rec_o[k], 0);
                check("t1_wfull", rec_w[k], 0);
            end
        end

        // Ramp then random data across the window-full boundary and wrap.
        do_reset();
        rand_busy = 1'b1;
        for (int n = 1; n <= 700; n++) begin
            push_val(vals[n]);
            repeat ($urandom_range(0, 2)) step();
        end
        wait_issues(700, 10000);
        if (rec_s.size() >= 700) begin
            check("t2_oldest_256", rec_o[255], 0);
            check("t2_wfull_256", rec_w[255], 0);
            check("t2_sample_257", rec_s[256], 257);
            check("t2_oldest_257", rec_o[256], 1);
            check("t2_wfull_257", rec_w[256], 1);
            check("t2_oldest_656", rec_o[655], -32768);
            check("t2_oldest_657", rec_o[656], 32767);
        end

        // Overflow while the engine is held busy.
        do_reset();
        force_busy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid  = 1'b1;
            in_sample = 16'(11 + i);
            step();
        end
        in_valid = 1'b0;
        check("t4_in_ready_full", int'(in_ready), 0);
        check("t4_overflow", int'(overflow_count), 2);
        force_busy = 1'b0;
        wait_issues(4, 300);
        repeat (20) step();
        check("t4_issue_count", rec_s.size(), 4);
        if (rec_s.size() >= 4) begin
            for (int k = 0; k < 4; k++) check("t4_sample", rec_s[k], 11 + k);
        end

        // Push and pop in the same cycle with three samples queued.
        force_busy = 1'b1;
        push_val(21);
        push_val(22);
        push_val(23);
        force_busy = 1'b0;
        in_valid   = 1'b1;
        in_sample  = 16'(24);
        step();
        in_valid = 1'b0;
        check("t6_in_ready_cnt3", int'(in_ready), 1);
        wait_issues(8, 300);
        if (rec_s.size() >= 8) begin
            for (int k = 0; k < 4; k++) check("t6_sample", rec_s[4 + k], 21 + k);
        end

        // Reset while waiting on the engine after 300 more samples.
        for (int n = 1; n <= 300; n++) push_val(1000 + n);
        rand_busy = 1'b0;
        busy_len  = 100;
        push_val(1301);
        wait_issues(309, 4000);
        repeat (5) step();
        check("t5_busy_before_reset", int'(sdft_busy), 1);
        do_reset();
        rand_busy = 1'b1;
        push_val(9);
        wait_issues(1, 50);
        if (rec_s.size() >= 1) begin
            check("t5_sample", rec_s[0], 9);
            check("t5_oldest", rec_o[0], 0);
        end
        repeat (10) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish, got t=%0t, expected < 900000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
